tp_wr_drain: RTL and testbench
==============================

TP_WR_DRAIN -- requirements
Module: tp_wr_drain

Interface
REQ-001 SHALL have parameter AW, default 16, address width matching the transposer write port.
REQ-002 SHALL have parameter BUFFD, default 64, data bytes per line (data width BUFFD*8).
REQ-003 SHALL have parameter DEPTH, default 8, FIFO entries, power of two, at least 4.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port init_pulse, input, 1, job start; same pulse the transposer receives.
REQ-007 SHALL have ports waddr / wdata / wdata_vld, inputs, AW / BUFFD*8 / 1, transposer write stream; no backpressure.
REQ-008 SHALL have port finish, input, 1, transposer job-finished pulse.
REQ-009 SHALL have ports mem_waddr / mem_wdata / mem_wvld, outputs, AW / BUFFD*8 / 1, SRAM write request.
REQ-010 SHALL have port mem_wready, input, 1, SRAM accepts the request when high with mem_wvld.
REQ-011 SHALL have port almost_full, output, 1, high when count >= DEPTH-2; the transposer may use it to stall reads.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when every job write has reached SRAM.
REQ-013 SHALL have ports err_ovf / err_unexp, outputs, 1 each, sticky error flags.

Function
REQ-014 SHALL be an FWFT FIFO: mem_wvld = !empty; mem_waddr and mem_wdata are the head entry, driven straight from registers.
REQ-015 SHALL pop when mem_wvld && mem_wready; mem_waddr and mem_wdata stay stable while mem_wvld is high and mem_wready is low.
REQ-016 SHALL push {waddr, wdata} when wdata_vld is high and state is ACTIVE or DRAIN; a write is visible on mem_wvld the next cycle (1-cycle latency).
REQ-017 SHALL, on simultaneous push and pop, keep count unchanged; this includes the full case, where the push is accepted.
REQ-018 SHALL, on a push while full without a pop, drop the write and set err_ovf; FIFO contents are unchanged.
REQ-019 SHALL, on wdata_vld in IDLE or DONE, drop the write and set err_unexp.
REQ-020 SHALL use DEPTH-wrapping read and write pointers and a count of width clog2(DEPTH+1); writes leave SRAM in strict input order.
REQ-021 SHALL implement state machine IDLE -> ACTIVE on init_pulse; ACTIVE -> DRAIN on finish; DRAIN -> DONE when count==0; DONE -> IDLE unconditionally; done = (state==DONE).
REQ-022 SHALL, on finish with count==0 and no push the same cycle, go through DRAIN for exactly one cycle, so done is asserted 2 cycles after finish.
REQ-023 SHALL, on init_pulse in any state, clear err_ovf, err_unexp and the FIFO, then enter ACTIVE; init_pulse wins over a same-cycle finish.
REQ-024 SHALL accept a write arriving in the same cycle as finish; that write drains before done.

Reset
REQ-025 SHALL, on reset high at a clk edge, set state=IDLE, pointers=0, count=0, mem_wvld=0, almost_full=0, done=0, err_ovf=0, err_unexp=0.
REQ-026 SHALL, on reset mid-job, discard pending entries without issuing further SRAM writes; reset overrides every other input.

Structure
REQ-027 SHALL place the state enum (IDLE, ACTIVE, DRAIN, DONE) in the shared package tp_pkg, alongside the AW and BUFFD defaults.
REQ-028 SHALL put the FIFO storage and pointers in sub-module tp_sync_fifo; tp_wr_drain holds the FSM, error flags and almost_full.

Verification
REQ-029 SHALL cover: init, 3 writes to 0x10/0x11/0x12 with mem_wready=1 -> 3 SRAM writes in order, each 1 cycle after input; finish -> done 2 cycles after the last pop.
REQ-030 SHALL cover: mem_wready=0, 8 writes -> count=8, almost_full high from the 6th write, mem_waddr stable; a 9th write -> err_ovf=1 and entry not stored.
REQ-031 SHALL cover: full FIFO, mem_wready=1 and wdata_vld in the same cycle -> count stays 8 and no err_ovf.
REQ-032 SHALL cover: write 0x20 in the same cycle as finish, mem_wready low for 5 cycles -> done only after 0x20 is popped.
REQ-033 SHALL cover: wdata_vld while IDLE -> err_unexp=1 and no mem_wvld; the next init_pulse -> err_unexp=0.
REQ-034 SHALL cover: reset with 4 entries pending -> mem_wvld=0 next cycle and no further SRAM writes.

Source files
------------

// File: rtl/tp_pkg.sv
// Shared definitions for the transposer write-drain path.
// Contents:
//   tp_state_t : drain FSM states (IDLE, ACTIVE, DRAIN, DONE)
//   AW_DEF     : default write-port address width
//   BUFFD_DEF  : default data bytes per line
package tp_pkg;

   localparam int AW_DEF    = 16;
   localparam int BUFFD_DEF = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } tp_state_t;

endpackage

// File: rtl/tp_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// The head entry is presented on dout straight from the storage registers,
// so a consumer sees it the cycle after it is pushed.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : synchronous flush (pointers and count back to zero)
//   push, din  : write request and data; accepted when not full or when
//                a pop happens in the same cycle
//   pop        : remove the head entry (ignored when empty)
//   dout       : head entry
//   empty/full : occupancy flags
//   count      : number of stored entries
module tp_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic          empty,
   output logic          full,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          do_push;
   logic          do_pop;

   assign empty = (count_reg == '0);
   assign full  = (count_reg == CW'(DEPTH));
   assign count = count_reg;
   assign dout  = mem[rd_ptr_reg];

   assign do_pop  = pop && !empty;
   // A push into a full FIFO is still taken when the head leaves this cycle.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage has no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !reset && !clear) mem[wr_ptr_reg] <= din;
   end

endmodule

// File: rtl/tp_wr_drain.sv
// Drains the transposer's unthrottled write stream into SRAM through a
// small FWFT FIFO and reports when every write of a job has landed.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   init_pulse            : job start; flushes the FIFO and clears errors
//   waddr/wdata/wdata_vld : transposer write stream (no backpressure)
//   finish                : transposer job-finished pulse
//   mem_waddr/mem_wdata/mem_wvld, mem_wready : SRAM write handshake
//   almost_full           : count >= DEPTH-2, lets the transposer stall
//   done                  : one-cycle pulse once the job has fully drained
//   err_ovf / err_unexp   : sticky overflow / write-outside-job flags
module tp_wr_drain
   import tp_pkg::*;
#(
   parameter int AW    = AW_DEF,
   parameter int BUFFD = BUFFD_DEF,
   parameter int DEPTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               init_pulse,
   input  logic [AW-1:0]      waddr,
   input  logic [BUFFD*8-1:0] wdata,
   input  logic               wdata_vld,
   input  logic               finish,
   output logic [AW-1:0]      mem_waddr,
   output logic [BUFFD*8-1:0] mem_wdata,
   output logic               mem_wvld,
   input  logic               mem_wready,
   output logic               almost_full,
   output logic               done,
   output logic               err_ovf,
   output logic               err_unexp
);

   localparam int DW = BUFFD * 8;
   localparam int CW = $clog2(DEPTH + 1);

   tp_state_t     state_reg;
   logic          err_ovf_reg;
   logic          err_unexp_reg;
   logic          fifo_empty;
   logic          fifo_full;
   logic [CW-1:0] fifo_count;
   logic          push_req;
   logic          pop_req;
   logic          in_job;
   logic [AW+DW-1:0] head;

   assign in_job   = (state_reg == ACTIVE) || (state_reg == DRAIN);
   // init_pulse flushes the FIFO, so a write in that same cycle is discarded.
   assign push_req = wdata_vld && in_job && !init_pulse;
   assign pop_req  = !fifo_empty && mem_wready;

   tp_sync_fifo #(
      .W     (AW + DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (init_pulse),
      .push  (push_req),
      .din   ({waddr, wdata}),
      .pop   (pop_req),
      .dout  (head),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   assign {mem_waddr, mem_wdata} = head;
   assign mem_wvld    = !fifo_empty;
   assign almost_full = (fifo_count >= CW'(DEPTH - 2));
   assign done        = (state_reg == DONE);
   assign err_ovf     = err_ovf_reg;
   assign err_unexp   = err_unexp_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         err_ovf_reg   <= 1'b0;
         err_unexp_reg <= 1'b0;
      end else if (init_pulse) begin
         state_reg     <= ACTIVE;
         err_ovf_reg   <= 1'b0;
         err_unexp_reg <= 1'b0;
      end else begin
         if (push_req && fifo_full && !pop_req) err_ovf_reg <= 1'b1;
         if (wdata_vld && !in_job)              err_unexp_reg <= 1'b1;
         case (state_reg)
            IDLE:    state_reg <= IDLE;
            ACTIVE:  if (finish) state_reg <= DRAIN;
            // A write landing in an empty FIFO still has to drain first.
            DRAIN:   if (fifo_count == '0 && !push_req) state_reg <= DONE;
            DONE:    state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tp_wr_drain.sv
module tb_tp_wr_drain;

   localparam int AW    = 16;
   localparam int BUFFD = 4;
   localparam int DW    = BUFFD * 8;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          init_pulse;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic          wdata_vld;
   logic          finish;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;
   logic          mem_wvld;
   logic          mem_wready;
   logic          almost_full;
   logic          done;
   logic          err_ovf;
   logic          err_unexp;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tp_wr_drain #(.AW(AW), .BUFFD(BUFFD), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .init_pulse  (init_pulse),
      .waddr       (waddr),
      .wdata       (wdata),
      .wdata_vld   (wdata_vld),
      .finish      (finish),
      .mem_waddr   (mem_waddr),
      .mem_wdata   (mem_wdata),
      .mem_wvld    (mem_wvld),
      .mem_wready  (mem_wready),
      .almost_full (almost_full),
      .done        (done),
      .err_ovf     (err_ovf),
      .err_unexp   (err_unexp)
   );

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
      return {16'hCAFE, a};
   endfunction

   task automatic do_init();
      init_pulse = 1'b1;
      tick();
      init_pulse = 1'b0;
   endtask

   task automatic set_write(input logic [AW-1:0] a);
      waddr     = a;
      wdata     = data_of(a);
      wdata_vld = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      if (mem_wvld !== 1'b0)    begin errors++; $display("FAIL reset_wvld got=%b exp=0", mem_wvld); end checks++;
      if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got=%b exp=0", almost_full); end checks++;
      if (done !== 1'b0)        begin errors++; $display("FAIL reset_done got=%b exp=0", done); end checks++;
      if (err_ovf !== 1'b0)     begin errors++; $display("FAIL reset_ovf got=%b exp=0", err_ovf); end checks++;
      if (err_unexp !== 1'b0)   begin errors++; $display("FAIL reset_unexp got=%b exp=0", err_unexp); end checks++;
      reset = 1'b0;
      tick();
      $display("reset: wvld=%b af=%b done=%b", mem_wvld, almost_full, done);
   endtask

   task automatic test_basic();
      logic [AW-1:0] a;
      do_init();
      mem_wready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = AW'(16'h10 + i);
         set_write(a);
         tick();
         $display("basic: wrote %h, sram head %h vld=%b", a, mem_waddr, mem_wvld);
         if (mem_wvld !== 1'b1)      begin errors++; $display("FAIL basic_wvld[%0d] got=%b exp=1", i, mem_wvld); end checks++;
         if (mem_waddr !== a)        begin errors++; $display("FAIL basic_addr[%0d] got=%h exp=%h", i, mem_waddr, a); end checks++;
         if (mem_wdata !== data_of(a)) begin errors++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, mem_wdata, data_of(a)); end checks++;
      end
      wdata_vld = 1'b0;
      tick();
      if (mem_wvld !== 1'b0) begin errors++; $display("FAIL basic_empty got=%b exp=0", mem_wvld); end checks++;
      finish = 1'b1;
      tick();
      finish = 1'b0;
      if (done !== 1'b0) begin errors++; $display("FAIL basic_done_early got=%b exp=0", done); end checks++;
      tick();
      if (done !== 1'b1) begin errors++; $display("FAIL basic_done got=%b exp=1", done); end checks++;
      tick();
      if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", done); end checks++;
      $display("basic: job finished");
   endtask

   task automatic test_overflow();
      logic [AW-1:0] a;
      do_init();
      mem_wready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         a = AW'(16'h30 + i);
         set_write(a);
         tick();
         $display("ovf: wrote %h af=%b head=%h", a, almost_full, mem_waddr);
         if (almost_full !== (i >= 5)) begin errors++; $display("FAIL ovf_af[%0d] got=%b exp=%b", i, almost_full, (i >= 5)); end checks++;
         if (mem_waddr !== 16'h30)     begin errors++; $display("FAIL ovf_head[%0d] got=%h exp=0030", i, mem_waddr); end checks++;
         if (err_ovf !== 1'b0)         begin errors++; $display("FAIL ovf_early[%0d] got=%b exp=0", i, err_ovf); end checks++;
      end
      set_write(16'h38);
      tick();
      wdata_vld = 1'b0;
      $display("ovf: 9th write err_ovf=%b", err_ovf);
      if (err_ovf !== 1'b1)     begin errors++; $display("FAIL ovf_flag got=%b exp=1", err_ovf); end checks++;
      if (mem_waddr !== 16'h30) begin errors++; $display("FAIL ovf_head9 got=%h exp=0030", mem_waddr); end checks++;
      mem_wready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a = AW'(16'h30 + i);
         if (mem_wvld !== 1'b1 || mem_waddr !== a) begin errors++; $display("FAIL ovf_drain[%0d] got=%b/%h exp=1/%h", i, mem_wvld, mem_waddr, a); end checks++;
         tick();
      end
      $display("ovf: drained, vld=%b", mem_wvld);
      if (mem_wvld !== 1'b0)    begin errors++; $display("FAIL ovf_not_stored got=%b exp=0", mem_wvld); end checks++;
      if (almost_full !== 1'b0) begin errors++; $display("FAIL ovf_af_clear got=%b exp=0", almost_full); end checks++;
      if (err_ovf !== 1'b1)     begin errors++; $display("FAIL ovf_sticky got=%b exp=1", err_ovf); end checks++;
   endtask

   task automatic test_full_push_pop();
      logic [AW-1:0] a;
      do_init();
      if (err_ovf !== 1'b0) begin errors++; $display("FAIL fpp_init_clr got=%b exp=0", err_ovf); end checks++;
      mem_wready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         set_write(AW'(16'h40 + i));
         tick();
      end
      mem_wready = 1'b1;
      set_write(16'h48);
      tick();
      $display("fpp: push+pop at full, ovf=%b head=%h", err_ovf, mem_waddr);
      if (err_ovf !== 1'b0)     begin errors++; $display("FAIL fpp_no_ovf got=%b exp=0", err_ovf); end checks++;
      if (almost_full !== 1'b1) begin errors++; $display("FAIL fpp_af got=%b exp=1", almost_full); end checks++;
      if (mem_waddr !== 16'h41) begin errors++; $display("FAIL fpp_head got=%h exp=0041", mem_waddr); end checks++;
      mem_wready = 1'b0;
      set_write(16'h49);
      tick();
      wdata_vld = 1'b0;
      if (err_ovf !== 1'b1) begin errors++; $display("FAIL fpp_still_full got=%b exp=1", err_ovf); end checks++;
      mem_wready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a = AW'(16'h41 + i);
         if (mem_wvld !== 1'b1 || mem_waddr !== a) begin errors++; $display("FAIL fpp_drain[%0d] got=%b/%h exp=1/%h", i, mem_wvld, mem_waddr, a); end checks++;
         tick();
      end
      if (mem_wvld !== 1'b0) begin errors++; $display("FAIL fpp_empty got=%b exp=0", mem_wvld); end checks++;
   endtask

   task automatic test_finish_write();
      do_init();
      mem_wready = 1'b0;
      set_write(16'h20);
      finish = 1'b1;
      tick();
      wdata_vld = 1'b0;
      finish    = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (done !== 1'b0)                               begin errors++; $display("FAIL fw_done_early[%0d] got=%b exp=0", i, done); end checks++;
         if (mem_wvld !== 1'b1 || mem_waddr !== 16'h20)   begin errors++; $display("FAIL fw_hold[%0d] got=%b/%h exp=1/0020", i, mem_wvld, mem_waddr); end checks++;
         tick();
      end
      mem_wready = 1'b1;
      tick();
      mem_wready = 1'b0;
      if (mem_wvld !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL fw_popped got=%b/%b exp=0/0", mem_wvld, done); end checks++;
      tick();
      $display("fw: after pop done=%b", done);
      if (done !== 1'b1) begin errors++; $display("FAIL fw_done got=%b exp=1", done); end checks++;
      tick();
   endtask

   task automatic test_unexp();
      set_write(16'h55);
      tick();
      wdata_vld = 1'b0;
      $display("unexp: idle write err_unexp=%b vld=%b", err_unexp, mem_wvld);
      if (err_unexp !== 1'b1) begin errors++; $display("FAIL unexp_flag got=%b exp=1", err_unexp); end checks++;
      if (mem_wvld !== 1'b0)  begin errors++; $display("FAIL unexp_wvld got=%b exp=0", mem_wvld); end checks++;
      tick();
      if (err_unexp !== 1'b1) begin errors++; $display("FAIL unexp_sticky got=%b exp=1", err_unexp); end checks++;
      do_init();
      if (err_unexp !== 1'b0) begin errors++; $display("FAIL unexp_clear got=%b exp=0", err_unexp); end checks++;
   endtask

   task automatic test_reset_mid();
      mem_wready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_write(AW'(16'h60 + i));
         tick();
      end
      wdata_vld = 1'b0;
      if (mem_wvld !== 1'b1) begin errors++; $display("FAIL rm_pending got=%b exp=1", mem_wvld); end checks++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mem_wready = 1'b1;
      $display("rm: reset with 4 pending, vld=%b", mem_wvld);
      if (mem_wvld !== 1'b0) begin errors++; $display("FAIL rm_wvld got=%b exp=0", mem_wvld); end checks++;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (mem_wvld !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rm_quiet[%0d] got=%b/%b exp=0/0", i, mem_wvld, done); end checks++;
      end
   endtask

   initial begin
      reset      = 1'b1;
      init_pulse = 1'b0;
      waddr      = '0;
      wdata      = '0;
      wdata_vld  = 1'b0;
      finish     = 1'b0;
      mem_wready = 1'b0;
      test_reset();
      test_basic();
      test_overflow();
      test_full_push_pop();
      test_finish_write();
      test_unexp();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
